p1v_io_ring: RTL and testbench
==============================

P1V_IO_RING -- requirements
Module: p1v_io_ring

Interface
REQ-001 Parameter NPINS, default 32, SHALL set the number of Propeller I/O pins handled.
REQ-002 Parameter NCOG, default 8, SHALL set the number of cog activity inputs; the LED count is 2*NCOG.
REQ-003 Parameter SYNC_STAGES, default 2, minimum 2, SHALL set the input synchroniser depth.
REQ-004 Parameter RESN_FILTER, default 16, minimum 1, SHALL set the number of consecutive stable cycles the pad reset needs before core_resn follows it.
REQ-005 Parameter STRETCH_CYCLES, default 1600000 (10 ms at 160 MHz), minimum 0, SHALL set the LED activity stretch length.
REQ-006 Parameter LED_ACTIVE_LOW, default 1, SHALL drive lit LEDs as 0 when 1 and as 1 when 0.
REQ-007 clock_160  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-008 inp_resn  in  1  SHALL be the block reset: synchronous, active-low.
REQ-009 pad_in  in  NPINS  SHALL carry the asynchronous pad input levels.
REQ-010 pad_out  out  NPINS  SHALL carry the registered pad output levels.
REQ-011 pad_oe  out  NPINS  SHALL carry the registered pad output enables; the top level performs the tristate.
REQ-012 pin_out, pin_dir  in  NPINS each  SHALL carry the core output value and direction.
REQ-013 pin_in  out  NPINS  SHALL carry the synchronised pad levels to the core.
REQ-014 pad_resn  in  1  SHALL carry the asynchronous external (USB serial) reset request, active-low.
REQ-015 core_resn  out  1  SHALL carry the filtered active-low reset to the core.
REQ-016 cogled  in  NCOG  SHALL carry the cog-running flags, synchronous to clock_160.
REQ-017 led  out  2*NCOG  SHALL drive the board LEDs: bits [NCOG-1:0] lit = cog active, bits [2*NCOG-1:NCOG] lit = cog inactive.

Function
REQ-018 pin_in[i] SHALL equal pad_in[i] delayed through exactly SYNC_STAGES flops, giving SYNC_STAGES cycles latency.
REQ-019 pad_out and pad_oe SHALL register pin_out and pin_dir with exactly 1 cycle latency; a pin with pad_oe=0 is an input.
REQ-020 pad_resn SHALL pass through its own SYNC_STAGES-flop synchroniser; call its output s.
REQ-021 The filter SHALL keep a counter: clear it when s == core_resn; when s != core_resn, increment it, except when it equals RESN_FILTER-1, in which case core_resn <= s and the counter clears.
REQ-022 Latency: with edge 1 the first edge that samples a new pad_resn level, core_resn SHALL change on edge SYNC_STAGES+RESN_FILTER.
REQ-023 A pad_resn glitch shorter than RESN_FILTER cycles, after synchronisation, SHALL leave core_resn unchanged.
REQ-024 For each cog i, the stretch counter SHALL load STRETCH_CYCLES when cogled[i]=1, decrement when cogled[i]=0 and it is nonzero, and hold at 0 otherwise.
REQ-025 The registered active flag for cog i SHALL update to cogled[i] OR (counter nonzero).
REQ-026 A cogled pulse of N cycles SHALL keep the active flag high for exactly N+STRETCH_CYCLES cycles, starting 1 cycle after the pulse begins.
REQ-027 A retrigger during the stretch SHALL reload the counter (no accumulation or wrap).
REQ-028 With STRETCH_CYCLES=0, the active flag SHALL be cogled delayed by 1 cycle.
REQ-029 led[i] SHALL show the active flag and led[NCOG+i] its inverse, both after LED_ACTIVE_LOW polarity.
REQ-030 Counter widths SHALL be $clog2(param+1); no counter SHALL overflow.

Reset
REQ-031 While inp_resn=0 at a rising edge, the block SHALL clear all synchroniser flops, pin_in, pad_out, pad_oe, the filter counter and the stretch counters to 0, and set core_resn=0.
REQ-032 While inp_resn=0, the active flags SHALL be 0, so led = {NCOG{~LED_ACTIVE_LOW}} in the upper half and {NCOG{LED_ACTIVE_LOW}} in the lower half.
REQ-033 Reset asserted mid-stretch or mid-filter SHALL abort it immediately; after release the block SHALL start from the reset state.

Verification
REQ-034 Defaults; pad_in=32'hA5A5_0F0F at edge 1 -> pin_in=32'hA5A5_0F0F after edge 2, not before.
REQ-035 pin_dir=32'h0000_FFFF, pin_out=32'h1234_5678 -> pad_oe=32'h0000_FFFF and pad_out=32'h1234_5678 one cycle later.
REQ-036 Release inp_resn with pad_resn=1 -> core_resn rises on edge 18; a 10-cycle pad_resn=0 glitch -> core_resn stays 1; 16-cycle low -> core_resn falls 18 edges after the first low sample.
REQ-037 STRETCH_CYCLES=4, LED_ACTIVE_LOW=1, 1-cycle cogled[3] pulse -> led[3]=0 for exactly 5 cycles and led[11]=1 for those cycles; a second pulse at cycle 3 -> led[3] stays 0 until 5 cycles after the second pulse.
REQ-038 inp_resn=0 asserted mid-stretch and mid-filter -> on the next edge led[7:0]=8'hFF, led[15:8]=8'h00, core_resn=0, pad_oe=0.

Source files
------------

// File: rtl/p1v_io_ring.sv
// Purpose : Propeller-1 pad ring: pin synchronisers, registered pad drive, pad reset filter, cog LEDs.
// Latency : pin_in SYNC_STAGES cycles, pad_out/pad_oe 1 cycle, core_resn SYNC_STAGES+RESN_FILTER, led 1.
// Backpr. : none; every input is sampled each clock_160 cycle and outputs are always valid.
//
// Ports:
//   clock_160, inp_resn     : clock and synchronous active-low block reset
//   pad_in  -> pin_in       : asynchronous pad levels, synchronised towards the core
//   pin_out/pin_dir -> pad_out/pad_oe : core drive, registered towards the pads (tristate is above us)
//   pad_resn -> core_resn   : asynchronous external reset request, synchronised and debounced
//   cogled  -> led          : cog-running flags, stretched for visibility; lower half active, upper inactive
module p1v_io_ring #(
    parameter int NPINS          = 32,
    parameter int NCOG           = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int RESN_FILTER    = 16,
    parameter int STRETCH_CYCLES = 1600000,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic                clock_160,
    input  logic                inp_resn,
    input  logic [NPINS-1:0]    pad_in,
    output logic [NPINS-1:0]    pad_out,
    output logic [NPINS-1:0]    pad_oe,
    input  logic [NPINS-1:0]    pin_out,
    input  logic [NPINS-1:0]    pin_dir,
    output logic [NPINS-1:0]    pin_in,
    input  logic                pad_resn,
    output logic                core_resn,
    input  logic [NCOG-1:0]     cogled,
    output logic [2*NCOG-1:0]   led
);

    localparam int FW  = $clog2(RESN_FILTER + 1);
    localparam int SW0 = $clog2(STRETCH_CYCLES + 1);
    // STRETCH_CYCLES=0 would give a zero-width counter; keep one bit that simply never leaves 0.
    localparam int SW  = (SW0 < 1) ? 1 : SW0;

    localparam logic [FW-1:0] FILT_LAST    = FW'(RESN_FILTER - 1);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES);
    localparam logic          LIT          = (LED_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    // Stage 0 is the pad-facing flop; stage SYNC_STAGES-1 feeds the core.
    logic [SYNC_STAGES-1:0][NPINS-1:0] pin_sync_q, pin_sync_d;
    logic [SYNC_STAGES-1:0]            resn_sync_q, resn_sync_d;
    logic [NPINS-1:0]                  pad_out_q, pad_out_d;
    logic [NPINS-1:0]                  pad_oe_q, pad_oe_d;
    logic [FW-1:0]                     filt_cnt_q, filt_cnt_d;
    logic                              core_resn_q, core_resn_d;
    logic [NCOG-1:0][SW-1:0]           str_cnt_q, str_cnt_d;
    logic [NCOG-1:0]                   active_q, active_d;
    logic                              resn_s;

    assign resn_s = resn_sync_q[SYNC_STAGES-1];

    always_comb begin
        pin_sync_d  = {pin_sync_q[SYNC_STAGES-2:0], pad_in};
        resn_sync_d = {resn_sync_q[SYNC_STAGES-2:0], pad_resn};
        pad_out_d   = pin_out;
        pad_oe_d    = pin_dir;

        // Debounce: core_resn only follows the synchronised request once it has
        // disagreed for RESN_FILTER consecutive cycles; any agreement restarts the count.
        filt_cnt_d  = '0;
        core_resn_d = core_resn_q;
        if (resn_s != core_resn_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                core_resn_d = resn_s;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end

        // Activity stretch: a running cog reloads its counter (retrigger, no
        // accumulation); the flag stays up until the counter has drained.
        for (int i = 0; i < NCOG; i++) begin
            str_cnt_d[i] = '0;
            if (cogled[i]) begin
                str_cnt_d[i] = STRETCH_LOAD;
            end else if (str_cnt_q[i] != '0) begin
                str_cnt_d[i] = str_cnt_q[i] - SW'(1);
            end
            active_d[i] = cogled[i] | (str_cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clock_160) begin
        if (!inp_resn) begin
            pin_sync_q  <= '0;
            resn_sync_q <= '0;
            pad_out_q   <= '0;
            pad_oe_q    <= '0;
            filt_cnt_q  <= '0;
            core_resn_q <= 1'b0;
            str_cnt_q   <= '0;
            active_q    <= '0;
        end else begin
            pin_sync_q  <= pin_sync_d;
            resn_sync_q <= resn_sync_d;
            pad_out_q   <= pad_out_d;
            pad_oe_q    <= pad_oe_d;
            filt_cnt_q  <= filt_cnt_d;
            core_resn_q <= core_resn_d;
            str_cnt_q   <= str_cnt_d;
            active_q    <= active_d;
        end
    end

    assign pin_in    = pin_sync_q[SYNC_STAGES-1];
    assign pad_out   = pad_out_q;
    assign pad_oe    = pad_oe_q;
    assign core_resn = core_resn_q;
    // Lower half lit when active, upper half lit when inactive.
    assign led = {active_q ^ {NCOG{LIT}}, ~(active_q ^ {NCOG{LIT}})};

endmodule

// File: tb/tb_p1v_io_ring.sv
// Purpose : directed bench for p1v_io_ring with a cycle-accurate reference model.
// Latency : model predicts outputs one edge at a time and is compared every cycle.
// Backpr. : not applicable.
module tb_p1v_io_ring;

    localparam int NPINS = 32;
    localparam int NCOG  = 8;
    localparam int SYNC  = 2;
    localparam int FILT  = 16;
    localparam int STR1  = 4;   // main instance: active-low LEDs, 4-cycle stretch
    localparam int STR2  = 0;   // second instance: active-high LEDs, no stretch

    logic               clock_160 = 1'b0;
    logic               inp_resn;
    logic [NPINS-1:0]   pad_in, pin_out, pin_dir;
    logic               pad_resn;
    logic [NCOG-1:0]    cogled;

    logic [NPINS-1:0]   pad_out, pad_oe, pin_in;
    logic               core_resn;
    logic [2*NCOG-1:0]  led;
    logic [NPINS-1:0]   pad_out2, pad_oe2, pin_in2;
    logic               core_resn2;
    logic [2*NCOG-1:0]  led2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock_160 = ~clock_160;

    p1v_io_ring #(.NPINS(NPINS), .NCOG(NCOG), .SYNC_STAGES(SYNC), .RESN_FILTER(FILT),
                  .STRETCH_CYCLES(STR1), .LED_ACTIVE_LOW(1)) u_dut (
        .clock_160(clock_160), .inp_resn(inp_resn), .pad_in(pad_in), .pad_out(pad_out),
        .pad_oe(pad_oe), .pin_out(pin_out), .pin_dir(pin_dir), .pin_in(pin_in),
        .pad_resn(pad_resn), .core_resn(core_resn), .cogled(cogled), .led(led));

    p1v_io_ring #(.NPINS(NPINS), .NCOG(NCOG), .SYNC_STAGES(SYNC), .RESN_FILTER(FILT),
                  .STRETCH_CYCLES(STR2), .LED_ACTIVE_LOW(0)) u_dut2 (
        .clock_160(clock_160), .inp_resn(inp_resn), .pad_in(pad_in), .pad_out(pad_out2),
        .pad_oe(pad_oe2), .pin_out(pin_out), .pin_dir(pin_dir), .pin_in(pin_in2),
        .pad_resn(pad_resn), .core_resn(core_resn2), .cogled(cogled), .led(led2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Pins/reset: last SYNC samples held in a queue. Filter: run length of
    // consecutive disagreeing cycles. Stretch: edge of the most recent cogled sample.
    logic [NPINS-1:0]   pq[$];
    logic               rq[$];
    logic [NPINS-1:0]   m_pin, m_out, m_oe;
    logic               m_core, s_old;
    int                 run;
    int                 edge_n = 0;
    int                 last_hit [NCOG];
    logic [2*NCOG-1:0]  m_led, m_led2;

    initial for (int i = 0; i < NCOG; i++) last_hit[i] = -1;

    always @(posedge clock_160) begin
        edge_n++;
        if (!inp_resn) begin
            pq.delete();
            rq.delete();
            m_out  = '0;
            m_oe   = '0;
            m_core = 1'b0;
            run    = 0;
            for (int i = 0; i < NCOG; i++) last_hit[i] = -1;
        end else begin
            s_old = (rq.size() == SYNC) ? rq[0] : 1'b0;
            pq.push_back(pad_in);
            if (pq.size() > SYNC) void'(pq.pop_front());
            rq.push_back(pad_resn);
            if (rq.size() > SYNC) void'(rq.pop_front());
            m_out = pin_out;
            m_oe  = pin_dir;
            if (s_old != m_core) begin
                run++;
                if (run == FILT) begin
                    m_core = s_old;
                    run    = 0;
                end
            end else begin
                run = 0;
            end
            for (int i = 0; i < NCOG; i++) if (cogled[i]) last_hit[i] = edge_n;
        end
        m_pin = (pq.size() == SYNC) ? pq[0] : '0;
        for (int i = 0; i < NCOG; i++) begin
            // active-low instance: lit = 0; active-high instance: lit = 1
            m_led[i]       = (last_hit[i] >= 0 && edge_n - last_hit[i] <= STR1) ? 1'b0 : 1'b1;
            m_led[NCOG+i]  = ~m_led[i];
            m_led2[i]      = (last_hit[i] >= 0 && edge_n - last_hit[i] <= STR2) ? 1'b1 : 1'b0;
            m_led2[NCOG+i] = ~m_led2[i];
        end
        #1;
        chk("model_pin_in", pin_in, m_pin);
        chk("model_pad_out", pad_out, m_out);
        chk("model_pad_oe", pad_oe, m_oe);
        chk("model_core_resn", core_resn, m_core);
        chk("model_led", led, m_led);
        chk("model_led_nostretch", led2, m_led2);
    end

    // ---------------- directed stimulus + literal checks ----------------
    initial begin
        inp_resn = 1'b0;
        pad_resn = 1'b1;
        pad_in   = '0;
        pin_out  = '0;
        pin_dir  = '0;
        cogled   = '0;
        repeat (3) @(negedge clock_160);
        chk("rst_core_resn", core_resn, 1'b0);
        chk("rst_led", led, 16'h00FF);
        chk("rst_led_activehigh", led2, 16'hFF00);
        chk("rst_pad_oe", pad_oe, 32'h0);
        chk("rst_pin_in", pin_in, 32'h0);

        // release; pins and reset filter start together
        inp_resn = 1'b1;
        pad_in   = 32'hA5A5_0F0F;
        pin_dir  = 32'h0000_FFFF;
        pin_out  = 32'h1234_5678;
        for (int e = 1; e <= 18; e++) begin
            @(negedge clock_160);
            if (e == 1) begin
                chk("pin_in_not_before_edge2", pin_in, 32'h0);
                chk("pad_oe_1cycle", pad_oe, 32'h0000_FFFF);
                chk("pad_out_1cycle", pad_out, 32'h1234_5678);
            end
            if (e == 2)  chk("pin_in_edge2", pin_in, 32'hA5A5_0F0F);
            if (e == 17) chk("core_resn_low_edge17", core_resn, 1'b0);
            if (e == 18) chk("core_resn_rise_edge18", core_resn, 1'b1);
        end

        // 10-cycle glitch is filtered
        pad_resn = 1'b0;
        repeat (10) @(negedge clock_160);
        pad_resn = 1'b1;
        repeat (30) @(negedge clock_160);
        chk("glitch10_ignored", core_resn, 1'b1);

        // 16-cycle low gets through on edge 18
        pad_resn = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            @(negedge clock_160);
            if (e == 16) pad_resn = 1'b1;
            if (e == 17) chk("low16_edge17", core_resn, 1'b1);
            if (e == 18) chk("low16_fall_edge18", core_resn, 1'b0);
        end
        repeat (20) @(negedge clock_160);
        chk("core_resn_recovered", core_resn, 1'b1);

        // single 1-cycle pulse on cog 3
        cogled[3] = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            @(negedge clock_160);
            if (e == 0) cogled[3] = 1'b0;
            chk("stretch_led3", led[3], (e <= 4) ? 1'b0 : 1'b1);
            chk("stretch_led11", led[11], (e <= 4) ? 1'b1 : 1'b0);
            if (e <= 1) chk("nostretch_led3", led2[3], (e == 0) ? 1'b1 : 1'b0);
        end
        repeat (3) @(negedge clock_160);

        // retrigger three cycles after the first pulse
        cogled[3] = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            @(negedge clock_160);
            if (e == 0 || e == 3) cogled[3] = 1'b0;
            if (e == 2) cogled[3] = 1'b1;
            chk("retrig_led3", led[3], (e <= 7) ? 1'b0 : 1'b1);
        end

        // reset in the middle of a stretch and a filter run
        pad_resn  = 1'b0;
        cogled[5] = 1'b1;
        @(negedge clock_160);
        cogled[5] = 1'b0;
        repeat (3) @(negedge clock_160);
        chk("pre_rst_led5", led[5], 1'b0);
        chk("pre_rst_core", core_resn, 1'b1);
        inp_resn = 1'b0;
        @(negedge clock_160);
        chk("midrst_led_lo", led[7:0], 8'hFF);
        chk("midrst_led_hi", led[15:8], 8'h00);
        chk("midrst_core", core_resn, 1'b0);
        chk("midrst_pad_oe", pad_oe, 32'h0);
        pad_resn = 1'b1;
        @(negedge clock_160);
        inp_resn = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            @(negedge clock_160);
            if (e == 17) chk("rerelease_edge17", core_resn, 1'b0);
            if (e == 18) chk("rerelease_edge18", core_resn, 1'b1);
        end
        repeat (3) @(negedge clock_160);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
